eth_rx_manchester: RTL

10BASE-T Manchester receive front end for the Tang Nano 9K design. It sits behind the LVDS input buffer on `eth_rx`, in the main PLL clock domain. It oversamples the line, recovers bits and detects the preamble/SFD, then delivers frame bytes through a FIFO on a valid/ready stream with last and error tags. Optional statistics counters are included. It generalises the fixed single-rate hookup to a configurable oversample ratio, preamble length and buffer depth.

---
 rtl/eth_rx_manchester.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/eth_rx_manchester.sv
// 10BASE-T Manchester receiver: oversampled bit recovery, preamble/SFD hunt, byte staging and FWFT output FIFO.
// Define ETH_RX_STATS_EN to build the frame_cnt/drop_cnt statistics counters; otherwise both read as zero.
module eth_rx_manchester #(
  parameter int OVS        = 8,
  parameter int MIN_PRE    = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        eth_rx,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        m_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        carrier,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt
);

  localparam int TW  = $clog2(3 * OVS / 2 + 2);
  localparam int PW  = $clog2(MIN_PRE + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;

  localparam logic [TW-1:0]  T_MAX     = TW'(3 * OVS / 2);
  localparam logic [TW-1:0]  T_LO      = TW'(3 * OVS / 4);
  localparam logic [TW-1:0]  T_HI      = TW'(5 * OVS / 4);
  localparam logic [PW-1:0]  PRE_MIN   = PW'(MIN_PRE);
  localparam logic [AW1-1:0] FIFO_FULL = AW1'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t          state;
  logic            sync0;
  logic            sync1;
  logic            level_q;
  logic            edge_q;
  logic [TW-1:0]   t;
  logic [TW-1:0]   elapsed;
  logic [PW-1:0]   pre_cnt;
  logic            prev_bit;
  logic [2:0]      bit_cnt;
  logic [6:0]      shreg;
  logic [7:0]      new_byte;
  logic [7:0]      stg_data;
  logic            stg_valid;
  logic            stg_last;
  logic            stg_err;
  logic            frame_err;
  logic            loss;
  logic            accept;
  logic            byte_done;
  logic            push;
  logic            pop;
  logic            space;
  logic            fifo_full;

  logic [9:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW1-1:0]  fifo_cnt;
  logic [9:0]      head;

  // Two-flop synchroniser followed by a registered edge detector; level_q is the line level after the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync0   <= 1'b0;
      sync1   <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync0   <= eth_rx;
      sync1   <= sync0;
      level_q <= sync1;
      edge_q  <= sync1 ^ level_q;
    end
  end

  // elapsed counts the current cycle, so an edge exactly OVS cycles after the last one sees elapsed == OVS.
  always_comb begin
    elapsed   = t + TW'(1);
    loss      = (state != IDLE) && (t == T_MAX);
    if (state == IDLE) begin
      accept = edge_q && !stg_valid;
    end else begin
      accept = edge_q && !loss && (elapsed >= T_LO) && (elapsed <= T_HI);
    end
    new_byte  = {level_q, shreg};
    byte_done = (state == DATA) && accept && (bit_cnt == 3'd7);
    fifo_full = (fifo_cnt == FIFO_FULL);
    pop       = m_valid && m_ready;
    space     = !fifo_full || pop;
    push      = stg_valid && space && (byte_done || (state == IDLE));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      carrier   <= 1'b0;
      t         <= '0;
      pre_cnt   <= '0;
      prev_bit  <= 1'b0;
      bit_cnt   <= 3'd0;
      shreg     <= 7'd0;
      stg_data  <= 8'd0;
      stg_valid <= 1'b0;
      stg_last  <= 1'b0;
      stg_err   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (accept) begin
        t <= '0;
      end else if ((state != IDLE) && (t != T_MAX)) begin
        t <= t + TW'(1);
      end

      if (push) begin
        stg_valid <= 1'b0;
        stg_last  <= 1'b0;
        stg_err   <= 1'b0;
      end

      // Carrier loss closes the frame; a staged byte becomes its last entry and waits for FIFO space.
      if (loss) begin
        state   <= IDLE;
        carrier <= 1'b0;
        bit_cnt <= 3'd0;
        if (stg_valid) begin
          stg_last <= 1'b1;
          stg_err  <= frame_err;
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state     <= PREAMBLE;
              carrier   <= 1'b1;
              prev_bit  <= level_q;
              pre_cnt   <= PW'(1);
              bit_cnt   <= 3'd0;
              frame_err <= 1'b0;
            end
          end

          PREAMBLE: begin
            if (accept) begin
              if (level_q == prev_bit) begin
                if (prev_bit && (pre_cnt >= PRE_MIN)) begin
                  state <= DATA;
                end else begin
                  state <= DROP;
                end
              end else if (pre_cnt != PRE_MIN) begin
                pre_cnt <= pre_cnt + PW'(1);
              end
              prev_bit <= level_q;
            end
          end

          DATA: begin
            if (accept) begin
              shreg   <= new_byte[7:1];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (!stg_valid || space) begin
                  stg_data  <= new_byte;
                  stg_valid <= 1'b1;
                end else begin
                  frame_err <= 1'b1;
                  state     <= DROP;
                end
              end
            end
          end

          DROP: begin
          end

          default: begin
            state   <= IDLE;
            carrier <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {stg_err, stg_last, stg_data};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + AW1'(1);
        2'b01:   fifo_cnt <= fifo_cnt - AW1'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign m_valid = (fifo_cnt != '0);
  assign m_data  = m_valid ? head[7:0] : 8'd0;
  assign m_last  = m_valid && head[8];
  assign m_err   = m_valid && head[9];

`ifdef ETH_RX_STATS_EN
  // Frames are counted when their last entry enters the FIFO, not when the consumer takes it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
    end else if (push && stg_last) begin
      if (stg_err) begin
        drop_cnt <= drop_cnt + 16'd1;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`else
  assign frame_cnt = 16'd0;
  assign drop_cnt  = 16'd0;
`endif

endmodule
